// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one synchronous memory between IF fetch and DM load/store through a 4-state FSM (ports: clk1/reset, halt, if_* fetch, dm_* data, mem_* memory side, busy)
module mips32_mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t state, state_d;
  logic [3:0] streak, streak_d;
  logic if_cand, grant_if, grant_dm, own_dm, own_we;
  always_ff @(posedge clk1 or posedge reset)
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_d;
      streak <= streak_d;
    end
  always_comb begin
    if_cand  = if_req & ~halt;
    grant_if = state == IDLE && if_cand && (!dm_req || streak == LIM);
    grant_dm = state == IDLE && dm_req && !grant_if;
    state_d  = state == IDLE  ? ((grant_if || grant_dm) ? ISSUE : IDLE) :
               state == ISSUE ? CAPT :
               state == CAPT  ? RESP : IDLE;
    streak_d = grant_if ? 4'd0 :
               grant_dm ? (if_cand ? (streak == LIM ? LIM : streak + 4'd1) : 4'd0) : streak;
  end
  always_ff @(posedge clk1 or posedge reset)
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      own_dm    <= 1'b0;
      own_we    <= 1'b0;
    end else begin
      mem_en <= grant_if | grant_dm;
      mem_we <= grant_dm & dm_we;
      if_ack <= state == CAPT && !own_dm;
      dm_ack <= state == CAPT && own_dm;
      if (grant_if || grant_dm) begin
        own_dm   <= grant_dm;
        own_we   <= grant_dm & dm_we;
        mem_addr <= grant_dm ? dm_addr : if_addr;
      end
      if (grant_dm) mem_wdata <= dm_wdata;
      if (state == CAPT && !own_dm) if_rdata <= mem_rdata;
      if (state == CAPT && own_dm && !own_we) dm_rdata <= mem_rdata;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed vector and sequence bench for the IF/DM memory arbiter
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  logic          clk1 = 1'b0, reset = 1'b1, halt = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata;
  logic          if_ack, dm_ack, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [1024];
  int tests = 0, fails = 0;
  typedef struct {
    bit          dm;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;
  vec_t vecs [9];
  byte  got [10];
  string exp_s;
  int n, both, ia, da;
  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk1(clk1), .reset(reset), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk1 = ~clk1;
  always @(posedge clk1)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " if_ack"}, 32'(if_ack), 0);
    chk({tag, " dm_ack"}, 32'(dm_ack), 0);
    chk({tag, " if_rdata"}, if_rdata, 0);
    chk({tag, " dm_rdata"}, dm_rdata, 0);
    chk({tag, " mem_en"}, 32'(mem_en), 0);
    chk({tag, " mem_we"}, 32'(mem_we), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b1, 10'd5,    32'h20410003, 32'h00000000, "st5"};
    vecs[1] = '{1'b0, 1'b0, 10'd5,    32'h0,        32'h20410003, "if5"};
    vecs[2] = '{1'b1, 1'b1, 10'd12,   32'hDEADBEEF, 32'h00000000, "st12"};
    vecs[3] = '{1'b1, 1'b0, 10'd12,   32'h0,        32'hDEADBEEF, "ld12"};
    vecs[4] = '{1'b1, 1'b1, 10'd1023, 32'hCAFEF00D, 32'hDEADBEEF, "st1023"};
    vecs[5] = '{1'b1, 1'b0, 10'd1023, 32'h0,        32'hCAFEF00D, "ld1023"};
    vecs[6] = '{1'b0, 1'b0, 10'd1023, 32'h0,        32'hCAFEF00D, "if1023"};
    vecs[7] = '{1'b1, 1'b0, 10'd5,    32'h0,        32'h20410003, "ld5"};
    vecs[8] = '{1'b0, 1'b0, 10'd12,   32'h0,        32'hDEADBEEF, "if12"};
    #12;
    chk_zero("reset");
    @(negedge clk1);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dm_req = vecs[i].dm; if_req = !vecs[i].dm; dm_we = vecs[i].we;
      dm_addr = vecs[i].addr; if_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
      @(posedge clk1); #1;
      chk({vecs[i].name, " mem_en"}, 32'(mem_en), 1);
      chk({vecs[i].name, " mem_we"}, 32'(mem_we), 32'(vecs[i].dm & vecs[i].we));
      chk({vecs[i].name, " mem_addr"}, 32'(mem_addr), 32'(vecs[i].addr));
      if (vecs[i].dm && vecs[i].we) chk({vecs[i].name, " mem_wdata"}, mem_wdata, vecs[i].wdata);
      @(posedge clk1); #1;
      chk({vecs[i].name, " mem_en_off"}, 32'(mem_en), 0);
      chk({vecs[i].name, " busy"}, 32'(busy), 1);
      @(posedge clk1); #1;
      chk({vecs[i].name, " if_ack"}, 32'(if_ack), 32'(!vecs[i].dm));
      chk({vecs[i].name, " dm_ack"}, 32'(dm_ack), 32'(vecs[i].dm));
      chk({vecs[i].name, " rdata"}, vecs[i].dm ? dm_rdata : if_rdata, vecs[i].exp_rd);
      dm_req = 1'b0; if_req = 1'b0;
      @(posedge clk1); #1;
      chk({vecs[i].name, " ack_end"}, 32'(if_ack | dm_ack), 0);
      chk({vecs[i].name, " idle"}, 32'(busy), 0);
    end
    exp_s = "DDDDIDDDDI";
    n = 0; both = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd12; if_req = 1'b1; if_addr = 10'd5;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(posedge clk1); #1;
      if (if_ack && dm_ack) both++;
      else if (dm_ack) begin got[n] = "D"; n++; end
      else if (if_ack) begin got[n] = "I"; n++; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    chk("contention acks", 32'(n), 10);
    chk("contention coincide", 32'(both), 0);
    for (int i = 0; i < 10; i++) if (i < n) chk($sformatf("grant%0d", i), 32'(got[i]), 32'(exp_s[i]));
    for (int c = 0; c < 8 && busy; c++) begin @(posedge clk1); #1; end
    chk("drain idle", 32'(busy), 0);
    halt = 1'b1; if_req = 1'b1; if_addr = 10'd1023; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd12;
    ia = 0; da = 0;
    repeat (12) begin @(posedge clk1); #1; ia += int'(if_ack); da += int'(dm_ack); end
    dm_req = 1'b0;
    repeat (4) begin @(posedge clk1); #1; ia += int'(if_ack); end
    chk("halt dm acks", 32'(da), 3);
    chk("halt if acks", 32'(ia), 0);
    chk("halt idle", 32'(busy), 0);
    halt = 1'b0;
    @(posedge clk1); #1;
    chk("unhalt mem_en", 32'(mem_en), 1);
    chk("unhalt mem_addr", 32'(mem_addr), 1023);
    chk("unhalt mem_we", 32'(mem_we), 0);
    halt = 1'b1;
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    chk("halt inflight if_ack", 32'(if_ack), 1);
    chk("halt inflight rdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0; halt = 1'b0;
    @(posedge clk1); #1;
    chk("halt end idle", 32'(busy), 0);
    if_req = 1'b1; if_addr = 10'd12;
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    chk("pre-reset busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_zero("async reset");
    @(posedge clk1); #1;
    chk("reset no if_ack", 32'(if_ack), 0);
    @(negedge clk1);
    reset = 1'b0;
    @(posedge clk1); #1;
    chk("resume mem_en", 32'(mem_en), 1);
    chk("resume mem_addr", 32'(mem_addr), 12);
    @(posedge clk1); #1;
    chk("resume no early ack", 32'(if_ack), 0);
    @(posedge clk1); #1;
    chk("resume if_ack", 32'(if_ack), 1);
    chk("resume rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    @(posedge clk1); #1;
    chk("resume idle", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
